// File: rtl/data_memory_pkg.sv
// Shared processor defaults for the data memory word width, address width and depth.
package data_memory_pkg;

  localparam int DM_DATA_W = 16;
  localparam int DM_ADDR_W = 16;
  localparam int DM_DEPTH  = 256;

  // Index width for a power-of-two depth; a single-word memory still needs one bit.
  function automatic int dm_idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/data_memory.sv
// Three-port word-addressed data memory.
// - Writes are synchronous and share one enable. On an address collision, port 3 wins over port 2, and port 2 wins over port 1.
// - Reads are asynchronous and OE-gated, with no write-through bypass.
// - Addresses wrap modulo DEPTH.
module data_memory
  import data_memory_pkg::*;
#(
  parameter int DATA_W = DM_DATA_W,
  parameter int ADDR_W = DM_ADDR_W,
  parameter int DEPTH  = DM_DEPTH
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pos1,
  input  logic [ADDR_W-1:0] pos2,
  input  logic [ADDR_W-1:0] pos3,
  input  logic [DATA_W-1:0] WD1,
  input  logic [DATA_W-1:0] WD2,
  input  logic [DATA_W-1:0] WD3,
  input  logic              OE,
  input  logic              wEnable,
  output logic [DATA_W-1:0] RD1,
  output logic [DATA_W-1:0] RD2,
  output logic [DATA_W-1:0] RD3
);

  localparam int IDX_W = dm_idx_w(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];

  logic [IDX_W-1:0] w_idx1;
  logic [IDX_W-1:0] w_idx2;
  logic [IDX_W-1:0] w_idx3;
  logic             w_unused_hi;

  // Only the low index bits select a word, so upper address bits wrap the address space.
  assign w_idx1 = pos1[IDX_W-1:0];
  assign w_idx2 = pos2[IDX_W-1:0];
  assign w_idx3 = pos3[IDX_W-1:0];
  assign w_unused_hi = ^{pos1, pos2, pos3};

  // Reset clears every word.
  // Otherwise, the ports write in order 1, 2, 3, so the later assignment wins on a shared address.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (wEnable) begin
      r_mem[w_idx1] <= WD1;
      r_mem[w_idx2] <= WD2;
      r_mem[w_idx3] <= WD3;
    end
  end

  // Read paths show the stored contents directly, or zero when the output enable is low.
  assign RD1 = OE ? r_mem[w_idx1] : '0;
  assign RD2 = OE ? r_mem[w_idx2] : '0;
  assign RD3 = OE ? r_mem[w_idx3] : '0;

endmodule

// File: tb/tb_data_memory.sv
// Directed, table-driven bench for data_memory.
// Each vector is applied, one clock edge follows, and the read ports are then compared.
module tb_data_memory;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] pos1, pos2, pos3;
  logic [15:0] WD1, WD2, WD3;
  logic        OE, wEnable;
  logic [15:0] RD1, RD2, RD3;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic        rst;
    logic        we;
    logic        oe;
    logic [15:0] p1, p2, p3;
    logic [15:0] w1, w2, w3;
    logic [15:0] e1, e2, e3;
    string       name;
  } vec_t;

  vec_t vecs[$];

  data_memory #(.DATA_W(16), .ADDR_W(16), .DEPTH(256)) dut (
    .clock   (clock),
    .reset   (reset),
    .pos1    (pos1),
    .pos2    (pos2),
    .pos3    (pos3),
    .WD1     (WD1),
    .WD2     (WD2),
    .WD3     (WD3),
    .OE      (OE),
    .wEnable (wEnable),
    .RD1     (RD1),
    .RD2     (RD2),
    .RD3     (RD3)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input string name, input logic rst, input logic we, input logic oe,
                     input logic [15:0] p1, input logic [15:0] p2, input logic [15:0] p3,
                     input logic [15:0] w1, input logic [15:0] w2, input logic [15:0] w3,
                     input logic [15:0] e1, input logic [15:0] e2, input logic [15:0] e3);
    vec_t v;
    v.name = name; v.rst = rst; v.we = we; v.oe = oe;
    v.p1 = p1; v.p2 = p2; v.p3 = p3;
    v.w1 = w1; v.w2 = w2; v.w3 = w3;
    v.e1 = e1; v.e2 = e2; v.e3 = e3;
    vecs.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    reset = v.rst; wEnable = v.we; OE = v.oe;
    pos1 = v.p1; pos2 = v.p2; pos3 = v.p3;
    WD1 = v.w1; WD2 = v.w2; WD3 = v.w3;
  endtask

  initial begin
    reset = 1'b0; wEnable = 1'b0; OE = 1'b0;
    pos1 = '0; pos2 = '0; pos3 = '0;
    WD1 = '0; WD2 = '0; WD3 = '0;

    //   name         rst we oe  p1       p2       p3       w1       w2       w3       e1       e2       e3
    add("reset",       1, 0, 0, 16'h0000, 16'h0004, 16'h0008, 16'h0, 16'h0, 16'h0, 16'h0000, 16'h0000, 16'h0000);
    add("oe_off",      0, 0, 0, 16'h0000, 16'h0004, 16'h0008, 16'h0, 16'h0, 16'h0, 16'h0000, 16'h0000, 16'h0000);
    add("rd_cleared",  0, 0, 1, 16'h0000, 16'h0004, 16'h0008, 16'h0, 16'h0, 16'h0, 16'h0000, 16'h0000, 16'h0000);
    add("triple_wr",   0, 1, 1, 16'h0000, 16'h0004, 16'h0008, 16'h0002, 16'h0003, 16'h0033, 16'h0002, 16'h0003, 16'h0033);
    add("wr_off_1",    0, 0, 1, 16'h0000, 16'h0004, 16'h0008, 16'h3FFF, 16'h1111, 16'h2222, 16'h0002, 16'h0003, 16'h0033);
    add("wr_off_2",    0, 0, 1, 16'h0000, 16'h0004, 16'h0008, 16'h3FFF, 16'h1111, 16'h2222, 16'h0002, 16'h0003, 16'h0033);
    add("wr_oe_low",   0, 1, 0, 16'h0005, 16'h0005, 16'h0005, 16'h0001, 16'h0002, 16'h0003, 16'h0000, 16'h0000, 16'h0000);
    add("collide_3",   0, 0, 1, 16'h0005, 16'h0005, 16'h0005, 16'h0, 16'h0, 16'h0, 16'h0003, 16'h0003, 16'h0003);
    add("p2_over_p1",  0, 1, 1, 16'h0001, 16'h0001, 16'h0002, 16'h0010, 16'h0020, 16'h0030, 16'h0020, 16'h0020, 16'h0030);
    add("p3_over_p1",  0, 1, 1, 16'h0009, 16'h000A, 16'h0009, 16'h0011, 16'h0022, 16'h0033, 16'h0033, 16'h0022, 16'h0033);
    add("full_width",  0, 1, 1, 16'h00FF, 16'h0080, 16'h0003, 16'hFFFF, 16'h8000, 16'h0001, 16'hFFFF, 16'h8000, 16'h0001);
    add("wrap_wr",     0, 1, 1, 16'h0107, 16'h0107, 16'h0107, 16'h00AA, 16'h00AA, 16'h00AA, 16'h00AA, 16'h00AA, 16'h00AA);
    add("wrap_rd",     0, 0, 1, 16'h0007, 16'hFF07, 16'h0000, 16'h0, 16'h0, 16'h0, 16'h00AA, 16'h00AA, 16'h0002);
    add("rst_over_we", 1, 1, 1, 16'h0000, 16'h0007, 16'h0005, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000);
    add("post_rst",    0, 0, 1, 16'h00FF, 16'h0080, 16'h0001, 16'h0, 16'h0, 16'h0, 16'h0000, 16'h0000, 16'h0000);

    foreach (vecs[i]) begin
      @(negedge clock);
      drive(vecs[i]);
      @(posedge clock);
      #1;
      chk({vecs[i].name, ".RD1"}, RD1, vecs[i].e1);
      chk({vecs[i].name, ".RD2"}, RD2, vecs[i].e2);
      chk({vecs[i].name, ".RD3"}, RD3, vecs[i].e3);
    end

    // Old contents must be visible until the write edge; new contents must be visible right after it.
    @(negedge clock);
    reset = 1'b0; OE = 1'b1; wEnable = 1'b1;
    pos1 = 16'h0014; pos2 = 16'h0014; pos3 = 16'h0015;
    WD1 = 16'h1234; WD2 = 16'h1234; WD3 = 16'h5678;
    #1;
    chk("pre_edge.RD1", RD1, 16'h0000);
    chk("pre_edge.RD3", RD3, 16'h0000);
    @(posedge clock);
    #1;
    chk("post_edge.RD1", RD1, 16'h1234);
    chk("post_edge.RD3", RD3, 16'h5678);

    // The output enable gates the read ports combinationally, with no clock edge needed.
    @(negedge clock);
    wEnable = 1'b0;
    OE = 1'b0;
    #1;
    chk("oe_drop.RD1", RD1, 16'h0000);
    chk("oe_drop.RD2", RD2, 16'h0000);
    OE = 1'b1;
    #1;
    chk("oe_raise.RD2", RD2, 16'h1234);

    // Reading with an address change alone must not require a clock edge.
    pos2 = 16'h0115;
    #1;
    chk("async_addr.RD2", RD2, 16'h5678);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/data_memory.md
DATA_MEMORY -- requirements
Module: data_memory

Interface
REQ-001 Parameter DATA_W, default 16, SHALL set the word width.
REQ-002 Parameter ADDR_W, default 16, SHALL set the address port width.
REQ-003 Parameter DEPTH, default 256, SHALL set the number of stored words (power of two, at most 2**ADDR_W).
REQ-004 The block SHALL have one clock; reset SHALL be synchronous and active-high.
REQ-005 clock  input  1  rising-edge clock for all state.
REQ-006 reset  input  1  synchronous, active-high clear.
REQ-007 pos1, pos2, pos3  input  ADDR_W  word addresses of ports 1, 2 and 3.
REQ-008 WD1, WD2, WD3  input  DATA_W  write data of ports 1, 2 and 3.
REQ-009 OE  input  1  output enable for all three read ports.
REQ-010 wEnable  input  1  common write enable for all three ports.
REQ-011 RD1, RD2, RD3  output  DATA_W  read data of ports 1, 2 and 3.

Function
REQ-012 The array SHALL be DEPTH words of DATA_W bits, word-addressed.
REQ-013 Only the low log2(DEPTH) address bits SHALL be used; upper bits are ignored, so addresses wrap modulo DEPTH.
REQ-014 Writes: on a rising clock edge with wEnable=1 and reset=0, WDn SHALL be written to mem[posn] for n=1,2,3 in the same cycle.
REQ-015 Write collision: if two or three ports address the same word in one write cycle, port 3 SHALL win over port 2, and port 2 over port 1.
REQ-016 With wEnable=0, memory contents SHALL be unchanged regardless of posn or WDn.
REQ-017 Writes SHALL NOT depend on OE.
REQ-018 Reads SHALL be combinational (asynchronous, zero latency): RDn = mem[posn] when OE=1.
REQ-019 When OE=0, RD1, RD2 and RD3 SHALL all be 0.
REQ-020 Read-after-write: after the write edge, RDn SHALL reflect the new contents with no extra cycle.
REQ-021 During the cycle before the write edge, RDn SHALL return the old contents (no write-through bypass).
REQ-022 Two or three ports reading the same address SHALL each return the same word.

Reset
REQ-023 On a rising edge with reset=1, every memory word SHALL be cleared to 0.
REQ-024 Reset SHALL take priority over wEnable; no write occurs in a reset cycle.
REQ-025 After reset with OE=1, all RDn SHALL read 0 until written.
REQ-026 Outputs SHALL remain combinational during reset (0 via OE=0 or the cleared contents).

Structure
REQ-027 DATA_W, ADDR_W and DEPTH defaults SHALL live in the shared processor package and be used as the parameter defaults.
REQ-028 The block SHALL be a single module with no sub-modules, containing:
  - one memory array;
  - one clocked process for reset and prioritised writes;
  - three combinational OE-gated read paths.

Verification
REQ-029 Output enable: pos1=0, pos2=4, pos3=8, OE=0, wEnable=0, one clock -> RD1=RD2=RD3=0.
REQ-030 Read before write: reset pulse, then OE=1, wEnable=0 -> RD1=RD2=RD3=0.
REQ-031 Triple write: WD1=0x0002, WD2=0x0003, WD3=0x0033, wEnable=1, one edge, then OE=1 -> RD1=0x0002, RD2=0x0003, RD3=0x0033.
REQ-032 Write disabled: wEnable=0, pos1=0, WD1=0x3FFF, clock twice -> RD1 stays 0x0002.
REQ-033 Collision: pos1=pos2=pos3=5, WD1=1, WD2=2, WD3=3, wEnable=1, one edge -> all RDn=3.
REQ-034 Wrap and reset: write 0x00AA at pos1=0x0107 (DEPTH=256) -> reading pos2=0x0007 gives 0x00AA; then reset edge -> RDn=0 everywhere.
